// File: rtl/tmr_irq_pkg.sv
// Shared types and constants for the timer interrupt arbiter.
// Optional ack timeout is controlled by the TMR_IRQ_TIMEOUT_EN macro.
package tmr_irq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        CLR       = 2'd2,
        WAIT_DROP = 2'd3
    } state_t;

    // Wide all-ones so any vector width can truncate it to its idle code.
    localparam logic [31:0] VEC_NONE = 32'hFFFF_FFFF;

    localparam int SRC_CMIA0 = 0;
    localparam int SRC_CMIB0 = 1;
    localparam int SRC_OVI0  = 2;
    localparam int SRC_CMIA1 = 3;
    localparam int SRC_CMIB1 = 4;
    localparam int SRC_OVI1  = 5;

endpackage

// File: rtl/tmr_irq_arbiter_if.sv
// Interrupt source / CPU handshake bundle for tmr_irq_arbiter.
// lost_irq exists only when TMR_IRQ_TIMEOUT_EN is defined.
interface tmr_irq_arbiter_if #(
    parameter int NUM_SRC   = 6,
    parameter int VEC_WIDTH = 3
);
    logic [NUM_SRC-1:0]   irq_src;
    logic                 rr_mode;
    logic                 irq_ack;
    logic                 irq_req;
    logic [VEC_WIDTH-1:0] irq_vec;
    logic [NUM_SRC-1:0]   flag_clr;
    logic                 busy;
`ifdef TMR_IRQ_TIMEOUT_EN
    logic                 lost_irq;

    modport master (output irq_src, rr_mode, irq_ack,
                    input  irq_req, irq_vec, flag_clr, busy, lost_irq);
    modport slave  (input  irq_src, rr_mode, irq_ack,
                    output irq_req, irq_vec, flag_clr, busy, lost_irq);
`else
    modport master (output irq_src, rr_mode, irq_ack,
                    input  irq_req, irq_vec, flag_clr, busy);
    modport slave  (input  irq_src, rr_mode, irq_ack,
                    output irq_req, irq_vec, flag_clr, busy);
`endif
endinterface

// File: rtl/tmr_rr_picker.sv
// Combinational rotating-priority picker: first set request scanning upward
// from start (round-robin) or from index 0 (fixed), wrapping at NUM_SRC-1.
module tmr_rr_picker #(
    parameter int NUM_SRC   = 6,
    parameter int VEC_WIDTH = 3
) (
    input  logic [NUM_SRC-1:0]   req,
    input  logic [VEC_WIDTH-1:0] start,
    input  logic                 mode,
    output logic [VEC_WIDTH-1:0] idx,
    output logic                 valid
);

    always_comb begin
        int base;
        int p;
        idx   = '0;
        valid = 1'b0;
        base  = mode ? int'(start) : 0;
        p     = 0;
        // Scan from the farthest offset down so the nearest hit is written last.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            p = base + i;
            if (p >= NUM_SRC) begin
                p = p - NUM_SRC;
            end
            if (req[p]) begin
                idx   = p[VEC_WIDTH-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tmr_irq_arbiter.sv
// Arbitrates the six timer interrupt flags onto one CPU request with a
// vector/ack handshake and flag-clear strobe. Optional: TMR_IRQ_TIMEOUT_EN.
module tmr_irq_arbiter
    import tmr_irq_pkg::*;
#(
    parameter int NUM_SRC     = 6,
    parameter int VEC_WIDTH   = 3,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    tmr_irq_arbiter_if.slave bus
);

    localparam logic [VEC_WIDTH-1:0] VEC_IDLE = VEC_WIDTH'(VEC_NONE);

    state_t               state_reg;
    logic [VEC_WIDTH-1:0] grant_reg;
    logic [VEC_WIDTH-1:0] rr_ptr_reg;
    logic                 irq_req_reg;
    logic [VEC_WIDTH-1:0] irq_vec_reg;
    logic [NUM_SRC-1:0]   flag_clr_reg;
    logic                 busy_reg;

    logic [VEC_WIDTH-1:0] pick_idx;
    logic                 pick_valid;
    logic [VEC_WIDTH-1:0] rr_ptr_next;

    tmr_rr_picker #(
        .NUM_SRC   (NUM_SRC),
        .VEC_WIDTH (VEC_WIDTH)
    ) u_picker (
        .req   (bus.irq_src),
        .start (rr_ptr_reg),
        .mode  (bus.rr_mode),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign rr_ptr_next = (grant_reg == VEC_WIDTH'(NUM_SRC - 1)) ? '0 : grant_reg + 1'b1;

`ifdef TMR_IRQ_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_reg;
    logic            lost_reg;
    assign bus.lost_irq = lost_reg;
`else
    wire unused_timeout_cfg = (ACK_TIMEOUT > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            rr_ptr_reg   <= '0;
            irq_req_reg  <= 1'b0;
            irq_vec_reg  <= VEC_IDLE;
            flag_clr_reg <= '0;
            busy_reg     <= 1'b0;
`ifdef TMR_IRQ_TIMEOUT_EN
            to_cnt_reg   <= '0;
            lost_reg     <= 1'b0;
`endif
        end else begin
            flag_clr_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        grant_reg   <= pick_idx;
                        irq_req_reg <= 1'b1;
                        irq_vec_reg <= pick_idx;
                        busy_reg    <= 1'b1;
                        state_reg   <= REQ;
`ifdef TMR_IRQ_TIMEOUT_EN
                        to_cnt_reg  <= '0;
`endif
                    end
                end
                REQ: begin
                    // Ack takes precedence over a source that falls in the same cycle.
                    if (bus.irq_ack) begin
                        irq_req_reg  <= 1'b0;
                        flag_clr_reg <= NUM_SRC'(1) << grant_reg;
                        state_reg    <= CLR;
                    end else if (!bus.irq_src[grant_reg]) begin
                        irq_req_reg <= 1'b0;
                        irq_vec_reg <= VEC_IDLE;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end
`ifdef TMR_IRQ_TIMEOUT_EN
                    else if (to_cnt_reg == TO_W'(ACK_TIMEOUT - 1)) begin
                        irq_req_reg <= 1'b0;
                        irq_vec_reg <= VEC_IDLE;
                        busy_reg    <= 1'b0;
                        rr_ptr_reg  <= rr_ptr_next;
                        lost_reg    <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
`endif
                end
                CLR: begin
                    rr_ptr_reg <= rr_ptr_next;
                    state_reg  <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    // Hold off re-arbitration until the serviced level is gone.
                    if (!bus.irq_src[grant_reg]) begin
                        irq_vec_reg <= VEC_IDLE;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.irq_req  = irq_req_reg;
    assign bus.irq_vec  = irq_vec_reg;
    assign bus.flag_clr = flag_clr_reg;
    assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_tmr_irq_arbiter.sv
// Directed bench for tmr_irq_arbiter; covers the timeout path when
// TMR_IRQ_TIMEOUT_EN is defined.
module tb_tmr_irq_arbiter;
    import tmr_irq_pkg::*;

    localparam logic [2:0] IDLE_VEC = 3'b111;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    tmr_irq_arbiter_if #(.NUM_SRC(6), .VEC_WIDTH(3)) bus ();

`ifdef TMR_IRQ_TIMEOUT_EN
    tmr_irq_arbiter #(.NUM_SRC(6), .VEC_WIDTH(3), .ACK_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`else
    tmr_irq_arbiter #(.NUM_SRC(6), .VEC_WIDTH(3), .ACK_TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.irq_src = '0;
        bus.rr_mode = 1'b0;
        bus.irq_ack = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic ack_pulse();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (bus.irq_req !== 1'b0 || bus.irq_vec !== IDLE_VEC || bus.flag_clr !== 6'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: req=%b vec=%0d clr=%b busy=%b required req=0 vec=7 clr=0 busy=0",
                     bus.irq_req, bus.irq_vec, bus.flag_clr, bus.busy);
        end
        // complete one handshake on CMIB0 so the rr pointer moves to 2
        bus.irq_src = 6'b000010;
        tick();
        ack_pulse();
        tick();
        bus.irq_src = 6'b000000;
        tick();
        // grant CMIB0 again and reset on the third REQ cycle
        bus.irq_src = 6'b000010;
        tick();
        tick();
        tick();
        total++;
        if (bus.irq_req !== 1'b1 || bus.irq_vec !== 3'(SRC_CMIB0)) begin
            bad++;
            $display("FAIL reset_pre_req: req=%b vec=%0d required req=1 vec=1", bus.irq_req, bus.irq_vec);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.irq_req !== 1'b0 || bus.irq_vec !== IDLE_VEC || bus.flag_clr !== 6'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: req=%b vec=%0d clr=%b busy=%b required req=0 vec=7 clr=0 busy=0",
                     bus.irq_req, bus.irq_vec, bus.flag_clr, bus.busy);
        end
        tick();
        bus.irq_src = 6'b000110;
        bus.rr_mode = 1'b1;
        rst = 1'b0;
        tick();
        // rr pointer back at 0 means source 1 wins over source 2
        total++;
        if (bus.irq_vec !== 3'd1 || bus.flag_clr !== 6'b0) begin
            bad++;
            $display("FAIL reset_rr_ptr: vec=%0d clr=%b required vec=1 clr=000000", bus.irq_vec, bus.flag_clr);
        end
        $display("reset: vec=%0d req=%b", bus.irq_vec, bus.irq_req);
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        bus.irq_src = 6'b100110;
        bus.rr_mode = 1'b0;
        tick();
        total++;
        if (bus.irq_req !== 1'b1 || bus.irq_vec !== 3'd1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL fixed_grant: req=%b vec=%0d busy=%b required req=1 vec=1 busy=1", bus.irq_req, bus.irq_vec, bus.busy);
        end
        ack_pulse();
        total++;
        if (bus.flag_clr !== 6'b000010 || bus.irq_req !== 1'b0) begin
            bad++;
            $display("FAIL fixed_clr: clr=%b req=%b required clr=000010 req=0", bus.flag_clr, bus.irq_req);
        end
        tick();
        total++;
        if (bus.flag_clr !== 6'b000000) begin
            bad++;
            $display("FAIL fixed_clr_width: clr=%b required 000000", bus.flag_clr);
        end
        bus.irq_src = 6'b100100;
        tick();
        total++;
        if (bus.irq_vec !== IDLE_VEC || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL fixed_drop_idle: vec=%0d busy=%b required vec=7 busy=0", bus.irq_vec, bus.busy);
        end
        tick();
        total++;
        if (bus.irq_vec !== 3'd2 || bus.irq_req !== 1'b1) begin
            bad++;
            $display("FAIL fixed_next: vec=%0d req=%b required vec=2 req=1", bus.irq_vec, bus.irq_req);
        end
        $display("fixed_priority: second vec=%0d", bus.irq_vec);
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq [7];
        logic [5:0] onehot;
        exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        apply_reset();
        bus.rr_mode = 1'b1;
        bus.irq_src = 6'b111111;
        for (int k = 0; k < 7; k++) begin
            tick();
            total++;
            if (bus.irq_vec !== exp_seq[k] || bus.irq_req !== 1'b1) begin
                bad++;
                $display("FAIL rr_grant_%0d: vec=%0d req=%b required vec=%0d req=1", k, bus.irq_vec, bus.irq_req, exp_seq[k]);
            end
            ack_pulse();
            onehot = 6'b000001 << exp_seq[k];
            total++;
            if (bus.flag_clr !== onehot) begin
                bad++;
                $display("FAIL rr_clr_%0d: clr=%b required %b", k, bus.flag_clr, onehot);
            end
            tick();
            bus.irq_src[exp_seq[k]] = 1'b0;
            tick();
            bus.irq_src = 6'b111111;
            $display("round_robin: step=%0d vec=%0d", k, exp_seq[k]);
        end
    endtask

    task automatic test_withdraw();
        apply_reset();
        bus.irq_src = 6'b001000;
        tick();
        tick();
        total++;
        if (bus.irq_req !== 1'b1 || bus.irq_vec !== 3'(SRC_CMIA1)) begin
            bad++;
            $display("FAIL withdraw_grant: req=%b vec=%0d required req=1 vec=3", bus.irq_req, bus.irq_vec);
        end
        bus.irq_src = 6'b000000;
        tick();
        total++;
        if (bus.irq_req !== 1'b0 || bus.irq_vec !== IDLE_VEC || bus.flag_clr !== 6'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL withdraw_idle: req=%b vec=%0d clr=%b busy=%b required req=0 vec=7 clr=0 busy=0",
                     bus.irq_req, bus.irq_vec, bus.flag_clr, bus.busy);
        end
        ack_pulse();
        total++;
        if (bus.flag_clr !== 6'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_ack_ignored: clr=%b busy=%b required clr=0 busy=0", bus.flag_clr, bus.busy);
        end
        $display("withdraw: req=%b vec=%0d", bus.irq_req, bus.irq_vec);
    endtask

    task automatic test_collision();
        apply_reset();
        bus.irq_src = 6'b000100;
        tick();
        bus.irq_ack = 1'b1;
        bus.irq_src = 6'b000000;
        tick();
        bus.irq_ack = 1'b0;
        total++;
        if (bus.flag_clr !== 6'b000100 || bus.irq_req !== 1'b0) begin
            bad++;
            $display("FAIL collision_clr: clr=%b req=%b required clr=000100 req=0", bus.flag_clr, bus.irq_req);
        end
        tick();
        total++;
        if (bus.busy !== 1'b1 || bus.irq_vec !== 3'd2 || bus.flag_clr !== 6'b0) begin
            bad++;
            $display("FAIL collision_wait: busy=%b vec=%0d clr=%b required busy=1 vec=2 clr=0", bus.busy, bus.irq_vec, bus.flag_clr);
        end
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.irq_vec !== IDLE_VEC) begin
            bad++;
            $display("FAIL collision_idle: busy=%b vec=%0d required busy=0 vec=7", bus.busy, bus.irq_vec);
        end
        $display("collision: clr issued, back to idle");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.irq_src = 6'b000001;
        tick();
        ack_pulse();
        tick();
        bus.irq_src = 6'b010001;
        tick();
        tick();
        // stale level on source 0 keeps us parked with no request
        total++;
        if (bus.busy !== 1'b1 || bus.irq_req !== 1'b0 || bus.irq_vec !== 3'd0) begin
            bad++;
            $display("FAIL stale_hold: busy=%b req=%b vec=%0d required busy=1 req=0 vec=0", bus.busy, bus.irq_req, bus.irq_vec);
        end
        bus.irq_src = 6'b010000;
        tick();
        tick();
        total++;
        if (bus.irq_vec !== 3'(SRC_CMIB1) || bus.irq_req !== 1'b1) begin
            bad++;
            $display("FAIL pending_next: vec=%0d req=%b required vec=4 req=1", bus.irq_vec, bus.irq_req);
        end
        $display("back_to_back: next vec=%0d", bus.irq_vec);
    endtask

`ifdef TMR_IRQ_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        bus.irq_src = 6'b000001;
        tick();
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (bus.irq_req !== 1'b1 || bus.lost_irq !== 1'b0) begin
                bad++;
                $display("FAIL timeout_hold_%0d: req=%b lost=%b required req=1 lost=0", c, bus.irq_req, bus.lost_irq);
            end
        end
        tick();
        total++;
        if (bus.irq_req !== 1'b0 || bus.lost_irq !== 1'b1 || bus.flag_clr !== 6'b0) begin
            bad++;
            $display("FAIL timeout_drop: req=%b lost=%b clr=%b required req=0 lost=1 clr=0", bus.irq_req, bus.lost_irq, bus.flag_clr);
        end
        bus.irq_src = 6'b000000;
        tick();
        tick();
        total++;
        if (bus.lost_irq !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: lost=%b required 1", bus.lost_irq);
        end
        apply_reset();
        total++;
        if (bus.lost_irq !== 1'b0) begin
            bad++;
            $display("FAIL timeout_rst_clear: lost=%b required 0", bus.lost_irq);
        end
        $display("timeout: lost_irq cleared by reset");
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.irq_src = '0;
        bus.rr_mode = 1'b0;
        bus.irq_ack = 1'b0;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_withdraw();
        test_collision();
        test_back_to_back();
`ifdef TMR_IRQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tmr_irq_arbiter.md
Name: tmr_irq_arbiter

Overview:
- Sequences the six timer interrupt requests (CMIA0, CMIB0, OVI0, CMIA1, CMIB1, OVI1) from the dual-channel 8-bit timer onto a single CPU interrupt line.
- Runs a vector/acknowledge handshake with the CPU.
- After acknowledge, issues a one-cycle flag-clear pulse back to the TCSR register logic for the granted source.
- Selects between fixed-priority and round-robin arbitration.

Parameters:
- NUM_SRC, 6, number of interrupt sources.
- VEC_WIDTH, 3, width of irq_vec; must satisfy 2^VEC_WIDTH > NUM_SRC.
- ACK_TIMEOUT, 255, cycles to wait for irq_ack before dropping the request (used only with the optional feature).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq_src  input  NUM_SRC  level requests {OVI1,CMIB1,CMIA1,OVI0,CMIB0,CMIA0}; index 0 = CMIA0.
- rr_mode  input  1  0 = fixed priority, 1 = round-robin.
- irq_ack  input  1  CPU acknowledge, single-cycle pulse.
- irq_req  output  1  interrupt request to CPU.
- irq_vec  output  VEC_WIDTH  granted source index; all-ones (VEC_NONE) when idle.
- flag_clr  output  NUM_SRC  one-hot, one-cycle clear strobe to the CMF/OVF bits.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE, irq_req=0, irq_vec=VEC_NONE, flag_clr=0, busy=0, rr_ptr=0, grant=0. Reset mid-handshake aborts with no flag_clr.
- All outputs are registered.

State machine:
- IDLE, REQ, CLR, WAIT_DROP.
- IDLE:
  - If |irq_src at edge N: latch grant = picked index; state=REQ.
  - irq_req=1 and irq_vec=grant visible from edge N, so latency is 1 cycle from the sampled request.
  - irq_ack in IDLE is ignored.
- REQ:
  - irq_req and irq_vec held stable.
  - On irq_ack at edge M: state=CLR; irq_req=0; flag_clr[grant]=1 for exactly the cycle after M.
  - If irq_src[grant] falls before ack (software cleared the flag): withdraw. State=IDLE, irq_req=0, irq_vec=VEC_NONE, no flag_clr.
  - If ack and the source falls in the same cycle, ack wins (CLR path).
- CLR:
  - One cycle.
  - flag_clr returns to 0.
  - rr_ptr <= (grant==NUM_SRC-1) ? 0 : grant+1.
  - Next state WAIT_DROP.
- WAIT_DROP:
  - Stays until irq_src[grant]==0, so a stale level is not re-serviced.
  - Then state=IDLE and irq_vec=VEC_NONE.
  - Other sources pending during WAIT_DROP are arbitrated in the following IDLE cycle.

Arbitration:
- Fixed: lowest set index wins.
- Round-robin: first set index scanning upward from rr_ptr, wrapping NUM_SRC-1 -> 0.
- rr_mode is sampled only at arbitration; changing it mid-handshake has no effect on the current grant.
- rr_ptr is updated in both modes but is used only when rr_mode=1.

Optional Feature:
- Macro TMR_IRQ_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(ACK_TIMEOUT+1) clears on entry to REQ and increments each REQ cycle.
  - When it reaches ACK_TIMEOUT without ack: state=IDLE, irq_req=0, no flag_clr, rr_ptr advanced as in CLR.
  - Extra output lost_irq (1 bit) is set sticky and cleared only by rst.
- Not defined: REQ waits indefinitely; there is no lost_irq port and no counter.

Decomposition:
- Package tmr_irq_pkg:
  - state enum (IDLE, REQ, CLR, WAIT_DROP).
  - VEC_NONE constant.
  - source index constants SRC_CMIA0..SRC_OVI1.
- Sub-module tmr_rr_picker:
  - Combinational rotating-priority picker.
  - Inputs req vector, start pointer, mode.
  - Outputs index and valid.

Test Plan:
- Reset mid-REQ: grant CMIB0, assert rst at cycle 3 -> irq_req=0, irq_vec=7, flag_clr=0, rr_ptr=0 immediately.
- Fixed priority: irq_src=6'b100110, rr_mode=0 -> irq_vec=1 one cycle later; ack -> flag_clr=6'b000010 for exactly one cycle; drop bit 1 -> next vec=2.
- Round-robin: irq_src=6'b111111 held with rr_mode=1 and each flag dropped after its clear -> grant sequence 0,1,2,3,4,5,0.
- Withdraw: grant vec=3, deassert irq_src[3] before ack -> irq_req=0 next cycle, no flag_clr, returns to IDLE.
- Ack/drop collision: irq_ack and irq_src[grant] fall in the same cycle -> flag_clr pulse issued, then IDLE after WAIT_DROP.
- TMR_IRQ_TIMEOUT_EN with ACK_TIMEOUT=4: no ack -> irq_req drops after 4 REQ cycles and lost_irq=1 stays set until rst.
